// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner: rotates a one-hot row drive, debounces one key at a time and
// reports each accepted press once, shifting it into a two-digit display register.
module keypad_scan_controller #(
  parameter int unsigned SCAN_DIV        = 4096,
  parameter int unsigned DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_sync,
  output logic [3:0] r_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] left,
  output logic [3:0] right
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);

  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  state_e           state_q, state_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       r_sel_q, r_sel_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       left_q, left_d;
  logic [3:0]       right_q, right_d;

  logic             col_single;
  logic [3:0]       lookup_code;

  // (row, col) -> hex legend printed on the keypad
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [3:0] col);
    logic [1:0] c;
    logic [3:0] code;
    case (col)
      4'b0001: c = 2'd0;
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      4'b1000: c = 2'd3;
      default: c = 2'd0;
    endcase
    case ({row, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Chords (several columns at once) are ambiguous and deliberately ignored.
  assign col_single  = (col_sync != 4'b0000) && ((col_sync & (col_sync - 4'd1)) == 4'b0000);
  assign lookup_code = key_lookup(row_q, col_q);

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    left_d      = left_q;
    right_d     = right_q;

    unique case (state_q)
      StScan: begin
        if (col_single) begin
          col_d    = col_sync;
          db_cnt_d = '0;
          state_d  = StDebounce;
        end else if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          row_d      = row_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      StDebounce: begin
        if (col_sync != col_q) begin
          // Bounce: retry the same row with a full dwell.
          scan_cnt_d = '0;
          state_d    = StScan;
        end else if (db_cnt_q == DbLast) begin
          db_cnt_d    = '0;
          key_valid_d = 1'b1;
          key_code_d  = lookup_code;
          left_d      = right_q;
          right_d     = lookup_code;
          state_d     = StHeld;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      StHeld: begin
        if (col_sync == 4'b0000) begin
          db_cnt_d = '0;
          state_d  = StRelease;
        end
      end

      StRelease: begin
        if (col_sync != 4'b0000) begin
          state_d = StHeld;
        end else if (db_cnt_q == DbLast) begin
          db_cnt_d   = '0;
          scan_cnt_d = '0;
          row_d      = row_q + 2'd1;
          state_d    = StScan;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: state_d = StScan;
    endcase

    r_sel_d = 4'b0001 << row_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StScan;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      row_q       <= 2'd0;
      r_sel_q     <= 4'b0001;
      col_q       <= 4'b0000;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      left_q      <= 4'h0;
      right_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      row_q       <= row_d;
      r_sel_q     <= r_sel_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  assign r_sel     = r_sel_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign left      = left_q;
  assign right     = right_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Scoreboard bench for keypad_scan_controller: stimulus queues expected key events,
// a negedge monitor pops and checks them whenever key_valid pulses.
module tb_keypad_scan_controller;

  localparam int ScanDiv  = 4;
  localparam int DbCycles = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_sync = 4'b0000;
  logic [3:0] r_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] left;
  logic [3:0] right;

  keypad_scan_controller #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_CYCLES(DbCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_sync (col_sync),
    .r_sel    (r_sel),
    .key_code (key_code),
    .key_valid(key_valid),
    .left     (left),
    .right    (right)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] code;
    logic [3:0] lft;
    logic [3:0] rgt;
    int         at_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_right = 4'h0;
  logic [3:0] pk = 4'h0, pl = 4'h0, pr = 4'h0;

  function automatic logic [3:0] oh(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return one << r;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every key_valid must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (reset) begin
      pk = key_code; pl = left; pr = right;
    end else if (key_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_key_valid: got code %h, expected no pulse (t=%0t)",
                 key_code, $time);
      end else begin
        mon_e = sb.pop_front();
        check4("key_code", key_code, mon_e.code);
        check4("left", left, mon_e.lft);
        check4("right", right, mon_e.rgt);
        check_int("key_valid_cycle", cyc, mon_e.at_cyc);
      end
      pk = key_code; pl = left; pr = right;
    end else begin
      n_vec++;
      if (key_code !== pk || left !== pl || right !== pr) begin
        n_err++;
        $display("FAIL outputs_changed_without_valid: got %h/%h/%h, expected %h/%h/%h",
                 key_code, left, right, pk, pl, pr);
      end
    end
  end

  // Returns at the first negedge on which row becomes the driven row.
  task automatic wait_row(input int row);
    int n;
    n = 0;
    while (r_sel == oh(row) && n < 64) begin @(negedge clk); n++; end
    while (r_sel != oh(row) && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_row_timeout: got r_sel %b, expected %b", r_sel, oh(row));
    end
  endtask

  task automatic press(input int row, input logic [3:0] cb, input logic [3:0] code);
    wait_row(row);
    col_sync = cb;
    sb.push_back('{code, exp_right, code, cyc + DbCycles + 1});
    exp_right = code;
    repeat (DbCycles + 4) @(negedge clk);
    check4("held_r_sel", r_sel, oh(row));
  endtask

  task automatic release_key(input int row, input logic [3:0] cb, input bit glitch);
    col_sync = 4'b0000;
    if (glitch) begin
      repeat (3) @(negedge clk);
      col_sync = cb;
      @(negedge clk);
      col_sync = 4'b0000;
    end
    repeat (DbCycles) @(negedge clk);
    check4("release_r_sel_frozen", r_sel, oh(row));
    @(negedge clk);
    check4("release_r_sel_next", r_sel, oh((row + 1) % 4));
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check4("rst_r_sel", r_sel, 4'b0001);
    check4("rst_key_code", key_code, 4'h0);
    check4("rst_key_valid", {3'b000, key_valid}, 4'h0);
    check4("rst_left", left, 4'h0);
    check4("rst_right", right, 4'h0);

    // Idle scanning
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check4("idle_r_sel_0", r_sel, 4'b0001);
    @(negedge clk);
    check4("idle_r_sel_1", r_sel, 4'b0010);
    for (int i = 2; i <= 4; i++) begin
      repeat (ScanDiv) @(negedge clk);
      check4("idle_r_sel_rot", r_sel, oh(i % 4));
    end

    // Key 8, then 5 with a release glitch, then 0
    press(2, 4'b0010, 4'h8);
    release_key(2, 4'b0010, 1'b0);
    press(1, 4'b0010, 4'h5);
    release_key(1, 4'b0010, 1'b1);
    press(3, 4'b0010, 4'h0);
    release_key(3, 4'b0010, 1'b0);
    check4("seq_left", left, 4'h5);
    check4("seq_right", right, 4'h0);

    // Bouncing press on row 0 col 1, then stable
    wait_row(0);
    for (int k = 0; k < 10; k++) begin
      col_sync = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (3) @(negedge clk);
    end
    col_sync = 4'b0010;
    sb.push_back('{4'h2, exp_right, 4'h2, cyc + DbCycles + 1});
    exp_right = 4'h2;
    repeat (DbCycles + 4) @(negedge clk);
    check4("bounce_held_r_sel", r_sel, 4'b0001);
    release_key(0, 4'b0010, 1'b0);

    // Two columns at once is not a key
    wait_row(0);
    col_sync = 4'b0011;
    for (int i = 1; i <= 4; i++) begin
      repeat (ScanDiv) @(negedge clk);
      check4("chord_r_sel_rot", r_sel, oh(i % 4));
    end
    col_sync = 4'b0000;

    // Reset four cycles into debounce of key 4
    wait_row(1);
    col_sync = 4'b0001;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    exp_right = 4'h0;
    #1;
    check4("mid_rst_r_sel", r_sel, 4'b0001);
    check4("mid_rst_key_valid", {3'b000, key_valid}, 4'h0);
    check4("mid_rst_key_code", key_code, 4'h0);
    check4("mid_rst_left", left, 4'h0);
    check4("mid_rst_right", right, 4'h0);
    col_sync = 4'b0000;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check4("post_rst_r_sel_0", r_sel, 4'b0001);
    @(negedge clk);
    check4("post_rst_r_sel_1", r_sel, 4'b0010);

    // Key A after the reset: history restarts from zero
    press(0, 4'b1000, 4'hA);
    release_key(0, 4'b1000, 1'b0);

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_key_valid: got no pulse, expected code %h at cycle %0d",
               mon_e.code, mon_e.at_cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
